multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the RV32I core datapath (PC, instruction memory, register file, ALU, data memory, writeback select). It replaces the single-cycle control unit. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB states, and waits on memory ready handshakes. It drives every datapath enable, the ALU opcode, the operand and writeback selects, and a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle sequencing controller for the RV32I datapath. Each instruction
// walks FETCH -> DECODE -> EXEC -> (MEM) -> WB. The controller waits in FETCH
// and MEM for the memory ready handshakes and counts retired instructions.
//
// Handshake: the controller holds a request (imem_req, or a non-zero memRW)
// level-high for as long as it stays in the owning state. The access
// completes in the cycle in which the matching ready input is 1. Ready
// inputs seen in any other state are ignored.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   run                permits a new fetch; sampled in IDLE and at retire
//   opcode/func3/func7 instruction register fields (stable from DECODE)
//   rd                 destination register index
//   imem_ready         instruction memory data valid
//   dmem_ready         data memory access completes
//   imem_req           fetch request
//   ir_en, pc_en       IR load / PC advance strobes (FETCH && imem_ready)
//   alu_en             ALU result register load strobe
//   ALUop, BSel        ALU operation, operand-B select (1 = immediate)
//   memRW              data memory command: 00 idle, 01 read, 10 write
//   WBsel              writeback source: 00 ALU, 01 memory
//   regWEn             register file write enable
//   illegal            sticky unsupported-opcode flag
//   state              current FSM state, for debug
//   retired            retired-instruction count, wraps modulo 2^CNT_W
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [4:0]       rd,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_en,
    output logic             pc_en,
    output logic             alu_en,
    output logic [3:0]       ALUop,
    output logic             BSel,
    output logic [1:0]       memRW,
    output logic [1:0]       WBsel,
    output logic             regWEn,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    state_t st;

    logic       is_r;
    logic       is_i;
    logic       is_load;
    logic       is_store;
    logic       legal;
    logic [3:0] alu_dec;
    logic       unused_func7;

    // Only func7[5] selects between operation variants.
    assign unused_func7 = ^{func7[6], func7[4:0]};

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign legal    = is_r | is_i | is_load | is_store;

    // Loads and stores fall through to ADD for address generation.
    // func7[5] picks SUB only for R-type (ADDI's immediate bits must not
    // turn it into SUB); it picks SRA/SRAI for both R and I forms.
    always_comb begin
        alu_dec = ALU_ADD;
        if (is_r || is_i) begin
            case (func3)
                3'b000:  alu_dec = (is_r && func7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_dec = ALU_SLL;
                3'b010:  alu_dec = ALU_SLT;
                3'b011:  alu_dec = ALU_SLTU;
                3'b100:  alu_dec = ALU_XOR;
                3'b101:  alu_dec = func7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_dec = ALU_OR;
                default: alu_dec = ALU_AND;
            endcase
        end
    end

    // IR load and PC advance are the only outputs with a combinational
    // path from a ready input; they fire in the cycle the fetch completes.
    assign ir_en = (st == FETCH) && imem_ready;
    assign pc_en = (st == FETCH) && imem_ready;
    assign state = st;

    // Outputs are registered: each transition loads the output values of
    // the state being entered, so they behave as Moore decodes of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            imem_req <= 1'b0;
            alu_en   <= 1'b0;
            ALUop    <= ALU_ADD;
            BSel     <= 1'b0;
            memRW    <= 2'b00;
            WBsel    <= 2'b00;
            regWEn   <= 1'b0;
            illegal  <= 1'b0;
            retired  <= '0;
        end else begin
            // Everything except the sticky flag and the counter drops unless
            // the entered state sets it again below.
            imem_req <= 1'b0;
            alu_en   <= 1'b0;
            ALUop    <= ALU_ADD;
            BSel     <= 1'b0;
            memRW    <= 2'b00;
            WBsel    <= 2'b00;
            regWEn   <= 1'b0;

            case (st)
                IDLE: begin
                    if (run) begin
                        st       <= FETCH;
                        imem_req <= 1'b1;
                    end
                end

                FETCH: begin
                    if (imem_ready) begin
                        st <= DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end

                DECODE: begin
                    if (legal) begin
                        st     <= EXEC;
                        alu_en <= 1'b1;
                        ALUop  <= alu_dec;
                        BSel   <= ~is_r;
                    end else begin
                        st      <= TRAP;
                        illegal <= 1'b1;
                    end
                end

                EXEC: begin
                    if (is_load || is_store) begin
                        st    <= MEM;
                        memRW <= is_load ? 2'b01 : 2'b10;
                    end else begin
                        st     <= WB;
                        regWEn <= (rd != 5'd0);
                    end
                end

                MEM: begin
                    if (!dmem_ready) begin
                        memRW <= is_load ? 2'b01 : 2'b10;
                    end else if (is_load) begin
                        st     <= WB;
                        WBsel  <= 2'b01;
                        regWEn <= (rd != 5'd0);
                    end else begin
                        // Store retires as soon as the write completes.
                        retired  <= retired + CNT_W'(1);
                        st       <= run ? FETCH : IDLE;
                        imem_req <= run;
                    end
                end

                WB: begin
                    retired  <= retired + CNT_W'(1);
                    st       <= run ? FETCH : IDLE;
                    imem_req <= run;
                end

                TRAP: begin
                    st <= TRAP;
                end

                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Instructions are expanded by a reference
// model into a per-cycle list of driven inputs and expected outputs, which is
// then replayed against the DUT. The counter is built 4 bits wide so that
// wraparound is reached within the run.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [6:0]    opcode = '0;
    logic [2:0]    func3 = '0;
    logic [6:0]    func7 = '0;
    logic [4:0]    rd = '0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, ir_en, pc_en, alu_en, BSel, regWEn, illegal;
    logic [3:0]    ALUop;
    logic [1:0]    memRW, WBsel;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run),
        .opcode(opcode), .func3(func3), .func7(func7), .rd(rd),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_en(ir_en), .pc_en(pc_en), .alu_en(alu_en),
        .ALUop(ALUop), .BSel(BSel), .memRW(memRW), .WBsel(WBsel),
        .regWEn(regWEn), .illegal(illegal), .state(state), .retired(retired)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- per-cycle record ----------------
    typedef struct {
        logic        rst, run, imem_ready, dmem_ready;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  rd;
        logic [2:0]  st;
        logic        imem_req, ir_en, pc_en, alu_en;
        logic [3:0]  aluop;
        logic        bsel;
        logic [1:0]  memrw, wbsel;
        logic        regwen, illegal;
        logic [31:0] retired;
    } cyc_t;

    cyc_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc_n    = 0;
    int   ret      = 0;

    // Expected ALU operation straight from the instruction set rules.
    function automatic logic [3:0] exp_alu(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        int base [8];
        int alt;
        base = '{0, 2, 3, 4, 5, 6, 8, 9};
        if (op == OP_LOAD || op == OP_STORE) return 4'd0;
        alt = (f7[5] && (f3 == 3'd5 || (f3 == 3'd0 && op == OP_R))) ? 1 : 0;
        return 4'(base[f3] + alt);
    endfunction

    // A cycle with random don't-care inputs and all outputs idle.
    function automatic cyc_t blank();
        cyc_t c;
        c.rst = 1'b0;
        c.run = 1'($urandom_range(0, 1));
        c.imem_ready = 1'($urandom_range(0, 1));
        c.dmem_ready = 1'($urandom_range(0, 1));
        c.opcode = 7'($urandom);
        c.func3 = 3'($urandom);
        c.func7 = 7'($urandom);
        c.rd = 5'($urandom);
        c.st = 3'd0;
        c.imem_req = 1'b0; c.ir_en = 1'b0; c.pc_en = 1'b0; c.alu_en = 1'b0;
        c.aluop = 4'd0; c.bsel = 1'b0; c.memrw = 2'b00; c.wbsel = 2'b00;
        c.regwen = 1'b0; c.illegal = 1'b0;
        c.retired = 32'(ret);
        return c;
    endfunction

    function automatic cyc_t instr_rec(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [4:0] r);
        cyc_t c;
        c = blank();
        c.opcode = op; c.func3 = f3; c.func7 = f7; c.rd = r;
        return c;
    endfunction

    task automatic retire_tail(input logic run_after);
        cyc_t c;
        ret = (ret + 1) % (1 << CW);
        if (!run_after) begin
            c = blank(); c.run = 1'b0; exp_q.push_back(c);
            c = blank(); c.run = 1'b0; exp_q.push_back(c);
            c = blank(); c.run = 1'b1; exp_q.push_back(c);
        end
    endtask

    // Reference model: one instruction from FETCH entry to its retire point.
    // iw/dw are memory wait cycles; rst_mem >= 0 pulses reset on that MEM cycle.
    task automatic gen(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r, input int iw, input int dw,
                       input logic run_after, input int rst_mem);
        cyc_t c;
        logic is_load, is_store, legal;
        is_load  = (op == OP_LOAD);
        is_store = (op == OP_STORE);
        legal    = is_load || is_store || op == OP_R || op == OP_I;

        for (int i = 0; i < iw; i++) begin
            c = blank(); c.st = 3'd1; c.imem_req = 1'b1; c.imem_ready = 1'b0;
            exp_q.push_back(c);
        end
        c = blank(); c.st = 3'd1; c.imem_req = 1'b1; c.imem_ready = 1'b1;
        c.ir_en = 1'b1; c.pc_en = 1'b1;
        exp_q.push_back(c);

        c = instr_rec(op, f3, f7, r); c.st = 3'd2;
        exp_q.push_back(c);

        if (!legal) begin
            for (int i = 0; i < 22; i++) begin
                c = instr_rec(op, f3, f7, r); c.st = 3'd6; c.illegal = 1'b1; c.run = 1'b1;
                exp_q.push_back(c);
            end
            ret = 0;
            c = instr_rec(op, f3, f7, r); c.rst = 1'b1; c.run = 1'b1;
            exp_q.push_back(c);
            return;
        end

        c = instr_rec(op, f3, f7, r); c.st = 3'd3; c.alu_en = 1'b1;
        c.aluop = exp_alu(op, f3, f7); c.bsel = (op != OP_R);
        exp_q.push_back(c);

        if (is_load || is_store) begin
            for (int i = 0; i <= dw; i++) begin
                c = instr_rec(op, f3, f7, r); c.st = 3'd4;
                c.dmem_ready = (i == dw);
                if (i == rst_mem) begin
                    ret = 0;
                    c.rst = 1'b1; c.run = 1'b1; c.dmem_ready = 1'b0;
                    c.st = 3'd0; c.retired = 32'd0;
                    exp_q.push_back(c);
                    return;
                end
                c.memrw = is_load ? 2'b01 : 2'b10;
                if (i == dw && is_store) begin
                    c.run = run_after;
                    exp_q.push_back(c);
                    retire_tail(run_after);
                    return;
                end
                exp_q.push_back(c);
            end
        end

        c = instr_rec(op, f3, f7, r); c.st = 3'd5;
        c.regwen = (r != 5'd0); c.wbsel = is_load ? 2'b01 : 2'b00; c.run = run_after;
        exp_q.push_back(c);
        retire_tail(run_after);
    endtask

    task automatic gen_random();
        logic [6:0] ops [4];
        logic [6:0] f7;
        logic [4:0] r;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE};
        f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
        r  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        gen(ops[$urandom_range(0, 3)], 3'($urandom), f7, r,
            $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc_n, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic play();
        cyc_t c;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            rst = c.rst; run = c.run;
            imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            opcode = c.opcode; func3 = c.func3; func7 = c.func7; rd = c.rd;
            #2;
            chk("state",    32'(state),    32'(c.st));
            chk("imem_req", 32'(imem_req), 32'(c.imem_req));
            chk("ir_en",    32'(ir_en),    32'(c.ir_en));
            chk("pc_en",    32'(pc_en),    32'(c.pc_en));
            chk("alu_en",   32'(alu_en),   32'(c.alu_en));
            chk("ALUop",    32'(ALUop),    32'(c.aluop));
            chk("BSel",     32'(BSel),     32'(c.bsel));
            chk("memRW",    32'(memRW),    32'(c.memrw));
            chk("WBsel",    32'(WBsel),    32'(c.wbsel));
            chk("regWEn",   32'(regWEn),   32'(c.regwen));
            chk("illegal",  32'(illegal),  32'(c.illegal));
            chk("retired",  32'(retired),  c.retired);
            if (c.rst) begin
                #1;
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc_n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc_t c;
        @(posedge clk);
        #1;
        // Reset cycle; released with run=1 so FETCH follows on the next edge.
        ret = 0;
        c = blank(); c.rst = 1'b1; c.run = 1'b1;
        exp_q.push_back(c);

        gen(OP_R,     3'b000, 7'h00, 5'd5,  0, 0, 1'b1, -1);  // ADD
        gen(OP_LOAD,  3'b010, 7'h00, 5'd3,  0, 3, 1'b1, -1);  // LW, 3 waits
        gen(OP_STORE, 3'b010, 7'h00, 5'd4,  0, 0, 1'b0, -1);  // SW then stop
        gen(OP_R,     3'b000, 7'h20, 5'd7,  1, 0, 1'b1, -1);  // SUB
        gen(OP_I,     3'b101, 7'h20, 5'd8,  0, 0, 1'b1, -1);  // SRAI
        gen(OP_I,     3'b000, 7'h20, 5'd9,  0, 0, 1'b1, -1);  // ADDI, imm[11:5]=0100000
        gen(OP_I,     3'b110, 7'h00, 5'd0,  2, 0, 1'b1, -1);  // ORI to x0
        gen(OP_LOAD,  3'b010, 7'h00, 5'd6,  0, 3, 1'b1, 1);   // reset inside MEM wait
        gen(OP_LOAD,  3'b000, 7'h00, 5'd0,  0, 1, 1'b1, -1);  // load to x0
        for (int i = 0; i < 26; i++) gen_random();
        gen(OP_BAD,   3'b000, 7'h00, 5'd1,  1, 0, 1'b1, -1);  // trap, then reset
        for (int i = 0; i < 6; i++) gen_random();

        play();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
